// File: rtl/ysyx_23060203_lsu.sv
// Load/store unit: accepts one memory operation at a time, rejects misaligned
// or illegal-funct requests locally, drives a word-aligned request with byte
// strobes, waits for the response and returns lane-shifted, extended load data.
module ysyx_23060203_lsu #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_wen,
    input  logic [2:0]  in_func,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_wen;
    logic [2:0]         r_func;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_rdata;
    logic               r_err;

    logic               w_in_legal;
    logic [4:0]         w_shamt;
    logic [31:0]        w_wdata_sh;
    logic [3:0]         w_strb;
    logic [31:0]        w_word;
    logic [31:0]        w_load;
    logic               w_expire;

    // Legality of the incoming request: funct encoding plus natural alignment.
    always_comb begin
        w_in_legal = 1'b1;
        if (in_wen) begin
            if (in_func[2] || (in_func[1:0] == 2'd3)) w_in_legal = 1'b0;
        end else begin
            if ((in_func == 3'd3) || (in_func == 3'd6) || (in_func == 3'd7)) w_in_legal = 1'b0;
        end
        case (in_func[1:0])
            2'd1:    if (in_addr[0]) w_in_legal = 1'b0;
            2'd2:    if (in_addr[1:0] != 2'b00) w_in_legal = 1'b0;
            default: ;
        endcase
    end

    // Byte-lane placement of store data and extraction/extension of load data.
    always_comb begin
        w_shamt    = {r_addr[1:0], 3'b000};
        w_wdata_sh = r_wdata << w_shamt;
        case (r_func[1:0])
            2'd0:    w_strb = 4'b0001 << r_addr[1:0];
            2'd1:    w_strb = 4'b0011 << r_addr[1:0];
            default: w_strb = 4'b1111;
        endcase
        w_word = mem_rdata >> w_shamt;
        case (r_func)
            3'd0:    w_load = {{24{w_word[7]}}, w_word[7:0]};
            3'd1:    w_load = {{16{w_word[15]}}, w_word[15:0]};
            3'd4:    w_load = {24'd0, w_word[7:0]};
            3'd5:    w_load = {16'd0, w_word[15:0]};
            default: w_load = w_word;
        endcase
        w_expire = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic and state-gated outputs (all outputs read zero outside their phase).
    always_comb begin
        w_next        = r_state;
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        mem_wen       = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_wstrb     = '0;
        out_valid     = 1'b0;
        out_rdata     = '0;
        out_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = w_in_legal ? S_REQ : S_DONE;
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                mem_wen       = r_wen;
                mem_addr      = {r_addr[31:2], 2'b00};
                mem_wdata     = r_wen ? w_wdata_sh : '0;
                mem_wstrb     = r_wen ? w_strb : '0;
                if (mem_req_ready) w_next = S_WAIT;
            end
            S_WAIT: begin
                // A response in the expiry cycle takes priority over the timeout.
                if (mem_resp_valid || w_expire) w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                out_rdata = r_rdata;
                out_err   = r_err;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request latch, timeout counter and result capture.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wen   <= 1'b0;
            r_func  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_wen   <= in_wen;
                        r_func  <= in_func;
                        r_addr  <= in_addr;
                        r_wdata <= in_wdata;
                        r_rdata <= '0;
                        r_err   <= ~w_in_legal;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) r_cnt <= '0;
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        r_rdata <= r_wen ? '0 : w_load;
                        r_err   <= 1'b0;
                    end else if (w_expire) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end else if (TIMEOUT != 0) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060203_lsu.sv
// Self-checking bench for ysyx_23060203_lsu: directed and randomized
// operations checked against an arithmetic reference model.
module tb_ysyx_23060203_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid, in_ready, in_wen;
    logic [2:0]  in_func;
    logic [31:0] in_addr, in_wdata;
    logic        mem_req_valid, mem_req_ready, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_23060203_lsu #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
        .in_func(in_func), .in_addr(in_addr), .in_wdata(in_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_rdata(out_rdata), .out_err(out_err)
    );

    // Reference model: access size from funct, legality from natural alignment,
    // lane placement and extension by plain integer arithmetic.
    function automatic void ref_model(input logic wen, input logic [2:0] func,
                                      input logic [31:0] addr, input logic [31:0] wdata,
                                      input logic [31:0] rdata, output logic legal,
                                      output logic [31:0] e_addr, output logic [31:0] e_wdata,
                                      output logic [3:0] e_wstrb, output logic [31:0] e_rdata);
        int nbytes, off, ifunc;
        longint v, span;
        ifunc = int'(func);
        off = int'(addr % 4);
        nbytes = (ifunc % 4 == 0) ? 1 : (ifunc % 4 == 1) ? 2 : 4;
        if (wen) legal = (ifunc < 3);
        else     legal = (ifunc < 6) && (ifunc != 3);
        if (off % nbytes != 0) legal = 1'b0;
        e_addr = addr - 32'(off);
        v = {32'd0, wdata} * (64'd1 << (8 * off));
        e_wdata = v[31:0];
        v = longint'(((1 << nbytes) - 1) << off);
        e_wstrb = v[3:0];
        v = {32'd0, rdata} / (64'd1 << (8 * off));
        span = 64'd1 << (8 * nbytes);
        if (nbytes < 4) v = v % span;
        if (ifunc < 4 && nbytes < 4 && v >= span / 2) v = v - span;
        e_rdata = (wen || !legal) ? 32'd0 : v[31:0];
    endfunction

    // Drive one operation through the full handshake sequence and check every phase.
    task automatic run_op(input string name, input logic wen, input logic [2:0] func,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int req_wait, input int resp_wait,
                          input int out_wait, input bit noise, input bit has_lit,
                          input logic [31:0] lit);
        logic legal, timeout, exp_err;
        logic [31:0] e_addr, e_wdata, e_rdata, exp_rd;
        logic [3:0] e_wstrb;
        int last;
        ref_model(wen, func, addr, wdata, rdata, legal, e_addr, e_wdata, e_wstrb, e_rdata);
        timeout = legal && (resp_wait >= TO);
        exp_err = !legal || timeout;
        exp_rd  = exp_err ? 32'd0 : e_rdata;

        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL %s accept: in_ready=%b want 1", name, in_ready);
        end
        in_valid = 1'b1; in_wen = wen; in_func = func; in_addr = addr; in_wdata = wdata;
        out_ready = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom; in_func = 3'($urandom);

        if (legal) begin
            for (int k = 0; k <= req_wait; k++) begin
                if (k > 0) @(negedge clk);
                checks++;
                if (mem_req_valid !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s req_phase: req_valid=%b out_valid=%b in_ready=%b want 1 0 0",
                             name, mem_req_valid, out_valid, in_ready);
                end
                checks++;
                if (mem_wen !== wen || mem_addr !== e_addr ||
                    mem_wstrb !== (wen ? e_wstrb : 4'b0000) || (wen && mem_wdata !== e_wdata)) begin
                    errors++;
                    $display("FAIL %s payload: wen=%b addr=%h wdata=%h wstrb=%b want %b %h %h %b",
                             name, mem_wen, mem_addr, mem_wdata, mem_wstrb,
                             wen, e_addr, e_wdata, wen ? e_wstrb : 4'b0000);
                end
                mem_resp_valid = noise ? 1'($urandom) : 1'b0;
                if (k == req_wait) mem_req_ready = 1'b1;
            end
            @(negedge clk);
            mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
            last = timeout ? TO : resp_wait + 1;
            for (int j = 1; j <= last; j++) begin
                if (j > 1) @(negedge clk);
                checks++;
                if (mem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s wait_phase: req_valid=%b out_valid=%b want 0 0",
                             name, mem_req_valid, out_valid);
                end
                if (!timeout && j == resp_wait + 1) begin
                    mem_resp_valid = 1'b1; mem_rdata = rdata;
                end
            end
            @(negedge clk);
            mem_resp_valid = 1'b0; mem_rdata = $urandom;
        end

        for (int k = 0; k <= out_wait; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_err !== exp_err || out_rdata !== exp_rd) begin
                errors++;
                $display("FAIL %s done: out_valid=%b err=%b rdata=%h want 1 %b %h",
                         name, out_valid, out_err, out_rdata, exp_err, exp_rd);
            end
            checks++;
            if (in_ready !== 1'b0 || mem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s done_ctl: in_ready=%b req_valid=%b want 0 0",
                         name, in_ready, mem_req_valid);
            end
            if (has_lit) begin
                checks++;
                if (out_rdata !== lit) begin
                    errors++;
                    $display("FAIL %s literal: out_rdata=%h want %h", name, out_rdata, lit);
                end
            end
            mem_resp_valid = noise ? 1'($urandom) : 1'b0;
            if (k == out_wait) out_ready = 1'b1;
        end
        @(negedge clk);
        out_ready = 1'b0; mem_resp_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: out_valid=%b in_ready=%b want 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_valid = 1'b0; in_wen = 1'b0; in_func = '0; in_addr = '0; in_wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0; out_ready = 1'b0;
        #2;
        checks++;
        if (in_ready !== 1'b1 || mem_req_valid !== 1'b0 || mem_wen !== 1'b0 || mem_addr !== 32'd0 ||
            mem_wdata !== 32'd0 || mem_wstrb !== 4'd0 || out_valid !== 1'b0 ||
            out_rdata !== 32'd0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b req_valid=%b addr=%h wstrb=%b out_valid=%b rdata=%h err=%b want 1 0 0 0 0 0 0",
                     in_ready, mem_req_valid, mem_addr, mem_wstrb, out_valid, out_rdata, out_err);
        end
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_lw();
        run_op("lw", 1'b0, 3'd2, 32'h8000_0008, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    endtask

    task automatic test_load_ext();
        run_op("lb",  1'b0, 3'd0, 32'h8000_0003, 32'h0, 32'h8011_2233, 0, 0, 0, 1'b0, 1'b1, 32'hFFFF_FF80);
        run_op("lbu", 1'b0, 3'd4, 32'h8000_0003, 32'h0, 32'h8011_2233, 0, 0, 0, 1'b0, 1'b1, 32'h0000_0080);
        run_op("lhu", 1'b0, 3'd5, 32'h8000_0002, 32'h0, 32'h8011_2233, 0, 0, 0, 1'b0, 1'b1, 32'h0000_8011);
        run_op("lh",  1'b0, 3'd1, 32'h8000_0002, 32'h0, 32'h8011_2233, 0, 0, 0, 1'b0, 1'b1, 32'hFFFF_8011);
        run_op("lb0", 1'b0, 3'd0, 32'h8000_0000, 32'h0, 32'h8011_2233, 0, 0, 0, 1'b0, 1'b1, 32'h0000_0033);
    endtask

    task automatic test_store();
        run_op("sh", 1'b1, 3'd1, 32'h8000_0006, 32'h0000_ABCD, 32'h1234_5678, 0, 0, 0, 1'b0, 1'b1, 32'h0);
        run_op("sb", 1'b1, 3'd0, 32'h8000_0001, 32'h0000_0055, 32'h0, 0, 1, 0, 1'b0, 1'b1, 32'h0);
        run_op("sw", 1'b1, 3'd2, 32'h8000_0010, 32'hCAFE_F00D, 32'h0, 0, 0, 0, 1'b0, 1'b1, 32'h0);
    endtask

    task automatic test_misaligned();
        run_op("lw_mis",  1'b0, 3'd2, 32'h8000_0002, 32'h0, 32'h0, 0, 0, 0, 1'b0, 1'b1, 32'h0);
        run_op("lh_mis",  1'b0, 3'd1, 32'h8000_0001, 32'h0, 32'h0, 0, 0, 0, 1'b0, 1'b1, 32'h0);
        run_op("sw_mis",  1'b1, 3'd2, 32'h8000_0003, 32'h1, 32'h0, 0, 0, 1, 1'b0, 1'b1, 32'h0);
        run_op("ld_f3",   1'b0, 3'd3, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0, 1'b0, 1'b1, 32'h0);
        run_op("st_f4",   1'b1, 3'd4, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0, 1'b0, 1'b1, 32'h0);
    endtask

    task automatic test_backpressure();
        run_op("bp_load",  1'b0, 3'd1, 32'h8000_0002, 32'h0, 32'hA5A5_7F01, 4, 1, 3, 1'b1, 1'b1, 32'h0000_A5A5 | 32'hFFFF_0000);
        run_op("bp_store", 1'b1, 3'd0, 32'h8000_0002, 32'h0000_00EE, 32'h0, 4, 0, 3, 1'b1, 1'b1, 32'h0);
    endtask

    task automatic test_timeout();
        run_op("timeout",   1'b0, 3'd2, 32'h8000_0004, 32'h0, 32'h1111_2222, 0, TO, 0, 1'b0, 1'b1, 32'h0);
        run_op("resp_wins", 1'b0, 3'd2, 32'h8000_0004, 32'h0, 32'h1111_2222, 0, TO - 1, 0, 1'b0, 1'b1, 32'h1111_2222);
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        in_valid = 1'b1; in_wen = 1'b0; in_func = 3'd2; in_addr = 32'h8000_0020;
        @(negedge clk);
        in_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || mem_req_valid !== 1'b0 || mem_addr !== 32'd0 || mem_wstrb !== 4'd0 ||
            out_valid !== 1'b0 || out_rdata !== 32'd0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: in_ready=%b req_valid=%b addr=%h out_valid=%b rdata=%h err=%b want 1 0 0 0 0 0",
                     in_ready, mem_req_valid, mem_addr, out_valid, out_rdata, out_err);
        end
        @(negedge clk);
        rstn = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL late_resp: out_valid=%b in_ready=%b req_valid=%b want 0 1 0",
                         out_valid, in_ready, mem_req_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            logic [2:0] f;
            int rw;
            f  = 3'($urandom_range(0, 7));
            rw = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, TO - 1);
            run_op("rand", 1'($urandom), f, $urandom, $urandom, $urandom,
                   $urandom_range(0, 2), rw, $urandom_range(0, 2), 1'b1, 1'b0, 32'h0);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_ext();
        test_store();
        test_misaligned();
        test_backpressure();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
